memory_to_dram: RTL and testbench
=================================

MEMORY_TO_DRAM -- requirements
Module: memory_to_dram

Interface
REQ-001 SHALL have parameter DATA_IN_BITWIDTH, default 163, memory word width.
REQ-002 SHALL have parameter DATA_OUT_BITWIDTH, default 8, DRAM-side chunk width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-004 SHALL have port clk_i  input  1  clock.
REQ-005 SHALL have port dram_to_mem_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  one-cycle transfer request.
REQ-007 SHALL have port base_addr_i  input  ADDR_WIDTH  first memory address.
REQ-008 SHALL have port num_words_i  input  ADDR_WIDTH  number of memory words to send.
REQ-009 SHALL have port mem_read_enable_o  output  1  memory read strobe.
REQ-010 SHALL have port mem_addr_o  output  ADDR_WIDTH  memory read address.
REQ-011 SHALL have port mem_data_i  input  DATA_IN_BITWIDTH  read data, valid exactly 1 cycle after the strobe.
REQ-012 SHALL have port data_out_o  output  DATA_OUT_BITWIDTH  DRAM-side chunk.
REQ-013 SHALL have port data_valid_o  output  1  data_out_o valid.
REQ-014 SHALL have port data_ready_i  input  1  DRAM side accepts the chunk.
REQ-015 SHALL have port busy_o  output  1  transfer in progress.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse at transfer end.

Function
REQ-017 SHALL unpack words into a contiguous bitstream, MSB first; chunk k = stream bits [k*8 .. k*8+7], earliest bit in data_out_o MSB.
REQ-018 SHALL carry leftover bits of a word (fewer than DATA_OUT_BITWIDTH) into the next chunk, followed by the MSBs of the next word; no gaps.
REQ-019 SHALL emit exactly ceil(num_words_i*DATA_IN_BITWIDTH/DATA_OUT_BITWIDTH) chunks; the final partial chunk is zero-padded in its LSBs.
REQ-020 SHALL use FSM states IDLE, FETCH, WAIT, DRAIN, FLUSH, DONE.
REQ-021 IDLE: start_i=1 with num_words_i>0 -> FETCH, latch base/count, busy_o=1; start_i with num_words_i=0 -> DONE, no reads.
REQ-022 FETCH: mem_read_enable_o=1 for one cycle at current address; address increments; -> WAIT.
REQ-023 WAIT: capture mem_data_i into the shift buffer below any residual bits; bit count += DATA_IN_BITWIDTH; -> DRAIN.
REQ-024 DRAIN: data_valid_o=1 while bit count >= DATA_OUT_BITWIDTH; on valid&&ready, shift out one chunk, bit count -= DATA_OUT_BITWIDTH.
REQ-025 DRAIN with bit count < DATA_OUT_BITWIDTH: words remaining -> FETCH; none and count>0 -> FLUSH; none and count=0 -> DONE.
REQ-026 FLUSH: present padded residual chunk with data_valid_o=1; on acceptance -> DONE.
REQ-027 DONE: done_o=1 for exactly one cycle, busy_o=0; -> IDLE.
REQ-028 data_out_o SHALL stay stable while data_valid_o=1 and data_ready_i=0; data_valid_o is never withdrawn before acceptance.
REQ-029 start_i SHALL be ignored unless in IDLE.
REQ-030 Shift buffer width SHALL be DATA_IN_BITWIDTH+DATA_OUT_BITWIDTH-1 bits; bit count width SHALL be $clog2 of that plus 1.
REQ-031 mem_addr_o SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-032 On dram_to_mem_rst_i, including mid-transfer: state IDLE; all outputs, shift buffer, bit count, address and word counter = 0.
REQ-033 No chunk SHALL be emitted in the cycle after reset release without a new start_i.

Structure
REQ-034 State encoding and buffer/count width constants SHALL live in a shared package mem_dram_pkg.
REQ-035 The shift buffer with bit count SHALL be one sub-module memory_to_dram_shift_buf; the FSM stays in the top.

Verification
REQ-036 N=1, word=all ones, ready=1 -> 21 chunks: 20×0xFF, last 0xE0; done_o pulses once.
REQ-037 N=2, word0=all ones, word1=0, ready=1 -> 41 chunks: 20×0xFF, 0xE0, 20×0x00; mem_addr_o = base, base+1.
REQ-038 N=1, ready toggled 1-0-1 every cycle -> data_out_o held while stalled; same 21 chunks in order, none lost or duplicated.
REQ-039 start_i with num_words_i=0 -> no mem_read_enable_o, done_o one cycle later, zero chunks.
REQ-040 Reset asserted after chunk 5 of N=2 -> outputs 0 immediately; a new start with N=1 yields correct 21 chunks.
REQ-041 base_addr_i=2^ADDR_WIDTH-1, N=2 -> reads at 1023 then 0.

Source files
------------

// File: rtl/mem_dram_pkg.sv
// Shared definitions for the memory-to-DRAM serializer: FSM encoding,
// default widths and helpers that size the shift buffer and its bit counter.
package mem_dram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_DATA_IN_BITWIDTH  = 163;
    localparam int DEF_DATA_OUT_BITWIDTH = 8;
    localparam int DEF_ADDR_WIDTH        = 10;

    // Worst case: one residual bit short of a chunk plus a whole new word.
    function automatic int buf_width(input int in_w, input int out_w);
        return in_w + out_w - 1;
    endfunction

    function automatic int cnt_width(input int in_w, input int out_w);
        return $clog2(in_w + out_w - 1) + 1;
    endfunction

endpackage

// File: rtl/memory_to_dram_shift_buf.sv
// MSB-aligned shift buffer: valid bits sit at the top, new words are merged
// directly below any residual bits, and chunks leave from the top.
module memory_to_dram_shift_buf
    import mem_dram_pkg::*;
#(
    parameter int DATA_IN_BITWIDTH  = DEF_DATA_IN_BITWIDTH,
    parameter int DATA_OUT_BITWIDTH = DEF_DATA_OUT_BITWIDTH,
    localparam int BUF_W = buf_width(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH),
    localparam int CNT_W = cnt_width(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH)
) (
    input  logic                         clk_i,
    input  logic                         dram_to_mem_rst_i,
    input  logic                         load_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [DATA_IN_BITWIDTH-1:0]  word_i,
    output logic [DATA_OUT_BITWIDTH-1:0] chunk_o,
    output logic [CNT_W-1:0]             cnt_o,
    output logic [CNT_W-1:0]             cnt_next_o
);

    logic [BUF_W-1:0] buf_r;
    logic [BUF_W-1:0] buf_next_s;
    logic [BUF_W-1:0] word_ext_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    assign word_ext_s = BUF_W'(word_i) << (DATA_OUT_BITWIDTH - 1);

    // Next buffer contents and bit count for load, pop or clear.
    always_comb begin
        buf_next_s = buf_r;
        cnt_next_s = cnt_r;
        if (clear_i) begin
            buf_next_s = {BUF_W{1'b0}};
            cnt_next_s = {CNT_W{1'b0}};
        end else if (load_i) begin
            buf_next_s = buf_r | (word_ext_s >> cnt_r);
            cnt_next_s = cnt_r + CNT_W'(DATA_IN_BITWIDTH);
        end else if (pop_i) begin
            buf_next_s = buf_r << DATA_OUT_BITWIDTH;
            cnt_next_s = cnt_r - CNT_W'(DATA_OUT_BITWIDTH);
        end else begin
            buf_next_s = buf_r;
            cnt_next_s = cnt_r;
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
        if (dram_to_mem_rst_i) begin
            buf_r <= {BUF_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            buf_r <= buf_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    // Bits below the residual are always zero, so a flush chunk is already padded.
    assign chunk_o    = buf_r[BUF_W-1 -: DATA_OUT_BITWIDTH];
    assign cnt_o      = cnt_r;
    assign cnt_next_o = cnt_next_s;

endmodule

// File: rtl/memory_to_dram.sv
// Reads num_words_i memory words from base_addr_i and streams them MSB first
// to the DRAM side as DATA_OUT_BITWIDTH chunks with a valid/ready handshake.
module memory_to_dram
    import mem_dram_pkg::*;
#(
    parameter int DATA_IN_BITWIDTH  = DEF_DATA_IN_BITWIDTH,
    parameter int DATA_OUT_BITWIDTH = DEF_DATA_OUT_BITWIDTH,
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         dram_to_mem_rst_i,
    input  logic                         start_i,
    input  logic [ADDR_WIDTH-1:0]        base_addr_i,
    input  logic [ADDR_WIDTH-1:0]        num_words_i,
    output logic                         mem_read_enable_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic [DATA_IN_BITWIDTH-1:0]  mem_data_i,
    output logic [DATA_OUT_BITWIDTH-1:0] data_out_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CNT_W = cnt_width(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(DATA_OUT_BITWIDTH);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_next_s;
    logic [ADDR_WIDTH-1:0]   words_left_r;
    logic [ADDR_WIDTH-1:0]   words_left_next_s;
    logic                    mem_read_enable_r;
    logic                    data_valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    load_s;
    logic                    pop_s;
    logic                    clear_s;
    logic [CNT_W-1:0]        cnt_s;
    logic [CNT_W-1:0]        cnt_next_s;

    memory_to_dram_shift_buf #(
        .DATA_IN_BITWIDTH  (DATA_IN_BITWIDTH),
        .DATA_OUT_BITWIDTH (DATA_OUT_BITWIDTH)
    ) u_shift_buf (
        .clk_i             (clk_i),
        .dram_to_mem_rst_i (dram_to_mem_rst_i),
        .load_i            (load_s),
        .pop_i             (pop_s),
        .clear_i           (clear_s),
        .word_i            (mem_data_i),
        .chunk_o           (data_out_o),
        .cnt_o             (cnt_s),
        .cnt_next_o        (cnt_next_s)
    );

    // Next-state, address/word bookkeeping and buffer commands.
    always_comb begin
        state_next_s      = state_r;
        addr_next_s       = addr_r;
        words_left_next_s = words_left_r;
        load_s            = 1'b0;
        pop_s             = 1'b0;
        clear_s           = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (num_words_i != {ADDR_WIDTH{1'b0}}) begin
                        state_next_s      = FETCH;
                        addr_next_s       = base_addr_i;
                        words_left_next_s = num_words_i;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                addr_next_s       = addr_r + ADDR_WIDTH'(1'b1);
                words_left_next_s = words_left_r - ADDR_WIDTH'(1'b1);
                state_next_s      = WAIT;
            end
            WAIT: begin
                load_s       = 1'b1;
                state_next_s = DRAIN;
            end
            DRAIN: begin
                if (cnt_s >= OUT_CNT) begin
                    pop_s        = data_valid_r & data_ready_i;
                    state_next_s = DRAIN;
                end else if (words_left_r != {ADDR_WIDTH{1'b0}}) begin
                    state_next_s = FETCH;
                end else if (cnt_s != {CNT_W{1'b0}}) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = DONE;
                end
            end
            FLUSH: begin
                if (data_valid_r && data_ready_i) begin
                    clear_s      = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; outputs are precomputed from next state
    // so every handshake/strobe output comes straight from a flop.
    always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
        if (dram_to_mem_rst_i) begin
            state_r           <= IDLE;
            addr_r            <= {ADDR_WIDTH{1'b0}};
            words_left_r      <= {ADDR_WIDTH{1'b0}};
            mem_read_enable_r <= 1'b0;
            data_valid_r      <= 1'b0;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            addr_r            <= addr_next_s;
            words_left_r      <= words_left_next_s;
            mem_read_enable_r <= (state_next_s == FETCH);
            data_valid_r      <= ((state_next_s == DRAIN) && (cnt_next_s >= OUT_CNT)) ||
                                 (state_next_s == FLUSH);
            busy_r            <= (state_next_s == FETCH) || (state_next_s == WAIT) ||
                                 (state_next_s == DRAIN) || (state_next_s == FLUSH);
            done_r            <= (state_next_s == DONE);
        end
    end

    assign mem_read_enable_o = mem_read_enable_r;
    assign mem_addr_o        = addr_r;
    assign data_valid_o      = data_valid_r;
    assign busy_o            = busy_r;
    assign done_o            = done_r;

endmodule

// File: tb/tb_memory_to_dram.sv
// Directed bench for memory_to_dram: synchronous memory model, negedge
// monitor collecting accepted chunks/read addresses, per-scenario tasks.
module tb_memory_to_dram;

    localparam int DIN  = 163;
    localparam int DOUT = 8;
    localparam int AW   = 10;

    logic            clk_i;
    logic            dram_to_mem_rst_i;
    logic            start_i;
    logic [AW-1:0]   base_addr_i;
    logic [AW-1:0]   num_words_i;
    logic            mem_read_enable_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DIN-1:0]  mem_data_i;
    logic [DOUT-1:0] data_out_o;
    logic            data_valid_o;
    logic            data_ready_i;
    logic            busy_o;
    logic            done_o;

    memory_to_dram #(
        .DATA_IN_BITWIDTH  (DIN),
        .DATA_OUT_BITWIDTH (DOUT),
        .ADDR_WIDTH        (AW)
    ) dut (
        .clk_i             (clk_i),
        .dram_to_mem_rst_i (dram_to_mem_rst_i),
        .start_i           (start_i),
        .base_addr_i       (base_addr_i),
        .num_words_i       (num_words_i),
        .mem_read_enable_o (mem_read_enable_o),
        .mem_addr_o        (mem_addr_o),
        .mem_data_i        (mem_data_i),
        .data_out_o        (data_out_o),
        .data_valid_o      (data_valid_o),
        .data_ready_i      (data_ready_i),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [DIN-1:0]  mem [0:(1<<AW)-1];
    logic [DIN-1:0]  junk_word;
    int              checks;
    int              failures;
    logic [DOUT-1:0] got_q[$];
    logic [AW-1:0]   rd_q[$];
    int              done_cnt;
    int              stall_err;
    bit              prev_stall;
    logic [DOUT-1:0] prev_data;

    // Read data appears one cycle after the strobe; otherwise a junk pattern.
    always @(posedge clk_i)
        mem_data_i <= mem_read_enable_o ? mem[mem_addr_o] : junk_word;

    // Monitor: accepted chunks, read addresses, done pulses, stall stability.
    always @(negedge clk_i) begin
        if (dram_to_mem_rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!data_valid_o || data_out_o !== prev_data)) stall_err++;
            if (data_valid_o && data_ready_i) got_q.push_back(data_out_o);
            if (mem_read_enable_o) rd_q.push_back(mem_addr_o);
            if (done_o) done_cnt++;
            prev_stall = data_valid_o && !data_ready_i;
            prev_data  = data_out_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        rd_q.delete();
        done_cnt  = 0;
        stall_err = 0;
    endtask

    task automatic run_transfer(input logic [AW-1:0] base, input logic [AW-1:0] n,
                                input bit toggle, input int stray_at);
        clear_mon();
        data_ready_i = 1'b1;
        base_addr_i  = base;
        num_words_i  = n;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%b exp=1", busy_o);
        end
        for (int i = 0; i < 3000; i++) begin
            if (toggle) data_ready_i = ~data_ready_i;
            if (i == stray_at) begin
                start_i     = 1'b1;
                base_addr_i = 10'd500;
                num_words_i = 10'd7;
            end else begin
                start_i = 1'b0;
            end
            tick();
            if (done_cnt != 0) break;
        end
        start_i      = 1'b0;
        data_ready_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL done_pulses got=%0d exp=1", done_cnt);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_reset();
        dram_to_mem_rst_i = 1'b1;
        #1;
        checks++;
        if ({data_valid_o, data_out_o, busy_o, done_o, mem_read_enable_o, mem_addr_o} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {data_valid_o, data_out_o, busy_o, done_o, mem_read_enable_o, mem_addr_o});
        end
        repeat (2) tick();
        dram_to_mem_rst_i = 1'b0;
        repeat (2) tick();
        checks++;
        if ({data_valid_o, busy_o, done_o, mem_read_enable_o} !== 4'd0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0000",
                     {data_valid_o, busy_o, done_o, mem_read_enable_o});
        end
    endtask

    task automatic test_single_ones();
        logic [DOUT-1:0] exp_q[$];
        mem[10] = {DIN{1'b1}};
        for (int i = 0; i < 20; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'hE0);
        run_transfer(10'd10, 10'd1, 1'b0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_chunk[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 10'd10) begin
            failures++;
            $display("FAIL single_reads got_n=%0d exp_n=1 addr0=%0d exp=10", rd_q.size(), rd_q[0]);
        end
    endtask

    task automatic test_two_words();
        logic [DOUT-1:0] exp_q[$];
        mem[100] = {DIN{1'b1}};
        mem[101] = {DIN{1'b0}};
        for (int i = 0; i < 20; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'hE0);
        for (int i = 0; i < 20; i++) exp_q.push_back(8'h00);
        run_transfer(10'd100, 10'd2, 1'b0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL two_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL two_chunk[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== 10'd100 || rd_q[1] !== 10'd101) begin
            failures++;
            $display("FAIL two_reads got_n=%0d exp_n=2 a0=%0d a1=%0d exp=100,101",
                     rd_q.size(), rd_q[0], rd_q[1]);
        end
    endtask

    task automatic test_bit_order();
        logic [DOUT-1:0] exp_q[$];
        mem[7] = {8'hA5, 154'd0, 1'b1};
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 19; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h20);
        run_transfer(10'd7, 10'd1, 1'b0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL order_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL order_chunk[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [DOUT-1:0] exp_q[$];
        mem[20] = {DIN{1'b1}};
        for (int i = 0; i < 20; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'hE0);
        run_transfer(10'd20, 10'd1, 1'b1, 3);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_chunk[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d exp=0", stall_err);
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 10'd20) begin
            failures++;
            $display("FAIL stall_reads got_n=%0d exp_n=1 addr0=%0d exp=20", rd_q.size(), rd_q[0]);
        end
    endtask

    task automatic test_zero_words();
        clear_mon();
        base_addr_i = 10'd5;
        num_words_i = 10'd0;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if ({done_o, busy_o, mem_read_enable_o} !== 3'b100) begin
            failures++;
            $display("FAIL zero_done got=%b exp=100", {done_o, busy_o, mem_read_enable_o});
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_width got=%b exp=0", done_o);
        end
        repeat (3) tick();
        checks++;
        if (rd_q.size() != 0 || got_q.size() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_activity reads=%0d chunks=%0d dones=%0d exp=0,0,1",
                     rd_q.size(), got_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [DOUT-1:0] exp_q[$];
        mem[30] = {DIN{1'b1}};
        mem[31] = {DIN{1'b1}};
        clear_mon();
        data_ready_i = 1'b1;
        base_addr_i  = 10'd30;
        num_words_i  = 10'd2;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 200 && got_q.size() < 5; i++) tick();
        checks++;
        if (got_q.size() != 5) begin
            failures++;
            $display("FAIL mid_reach5 got=%0d exp=5", got_q.size());
        end
        dram_to_mem_rst_i = 1'b1;
        #1;
        checks++;
        if ({data_valid_o, data_out_o, busy_o, done_o, mem_read_enable_o, mem_addr_o} !== 22'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {data_valid_o, data_out_o, busy_o, done_o, mem_read_enable_o, mem_addr_o});
        end
        repeat (2) tick();
        dram_to_mem_rst_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_q.size() != 5 || data_valid_o !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL mid_post_release chunks=%0d valid=%b dones=%0d exp=5,0,0",
                     got_q.size(), data_valid_o, done_cnt);
        end
        for (int i = 0; i < 20; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'hE0);
        run_transfer(10'd30, 10'd1, 1'b0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL mid_restart_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL mid_restart_chunk[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        mem[1023] = {DIN{1'b1}};
        mem[0]    = {DIN{1'b0}};
        run_transfer(10'd1023, 10'd2, 1'b0, -1);
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== 10'd1023 || rd_q[1] !== 10'd0) begin
            failures++;
            $display("FAIL wrap_reads got_n=%0d a0=%0d a1=%0d exp=2,1023,0",
                     rd_q.size(), rd_q[0], rd_q[1]);
        end
        checks++;
        if (got_q.size() != 41) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=41", got_q.size());
        end
        checks++;
        if (got_q.size() > 20 && got_q[20] !== 8'hE0) begin
            failures++;
            $display("FAIL wrap_chunk20 got=%h exp=e0", got_q[20]);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        done_cnt          = 0;
        stall_err         = 0;
        prev_stall        = 1'b0;
        prev_data         = 8'h00;
        dram_to_mem_rst_i = 1'b1;
        start_i           = 1'b0;
        base_addr_i       = 10'd0;
        num_words_i       = 10'd0;
        data_ready_i      = 1'b1;
        for (int i = 0; i < DIN; i++) junk_word[i] = (i % 2 == 0);
        for (int i = 0; i < (1 << AW); i++) mem[i] = {DIN{1'b0}};

        test_reset();
        test_single_ones();
        test_two_words();
        test_bit_order();
        test_stall();
        test_zero_words();
        test_reset_mid();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
